// File: rtl/vram_arb.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// vram_arb
//   Requester side of the single-port vram. Arbitrates the video fetch path and
//   the CPU register-interface path onto one vram port (1-cycle read latency).
//   Video has priority; a starvation counter lets a waiting CPU pre-empt video
//   after STARVE_LIMIT cycles (0 disables pre-emption). Read data returns to
//   each requester through registers, two cycles after the grant.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   vid_sel_in/addr_in  video read request (no handshake) and word address
//   vid_valid_out       pulse: vid_data_out carries a fresh word
//   vid_data_out        video read data, held between valid pulses
//   vid_miss_out        pulse: a video request was dropped for the CPU
//   regs_req_in         CPU request, held with wr/addr/data until ack
//   regs_wr_in          1 = write, 0 = read
//   regs_addr_in/data_in CPU word address / write data
//   regs_ack_out        one-cycle pulse: CPU access complete
//   regs_data_out       CPU read data, valid with ack, held until next read ack
//   vram_sel_out/wr_out/addr_out/data_out  combinational vram port drive
//   vram_data_in        vram read data (valid the cycle after sel)
// ----------------------------------------------------------------------------
module vram_arb #(
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_sel_in,
    input  logic [15:0] vid_addr_in,
    output logic        vid_valid_out,
    output logic [15:0] vid_data_out,
    output logic        vid_miss_out,
    input  logic        regs_req_in,
    input  logic        regs_wr_in,
    input  logic [15:0] regs_addr_in,
    input  logic [15:0] regs_data_in,
    output logic        regs_ack_out,
    output logic [15:0] regs_data_out,
    output logic        vram_sel_out,
    output logic        vram_wr_out,
    output logic [15:0] vram_addr_out,
    output logic [15:0] vram_data_out,
    input  logic [15:0] vram_data_in
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic PREEMPT_EN = (STARVE_LIMIT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUED,
        ST_ACK
    } state_t;

    // Owner of a vram issue. CPU writes are tagged NONE so the read data
    // returned for that cycle is thrown away.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CPU
    } tag_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    tag_t              tag1_q, tag1_d;     // owner of the data arriving this cycle
    tag_t              tag2_q, tag2_d;     // owner of the registered result
    logic [15:0]       vid_data_q, vid_data_d;
    logic [15:0]       regs_data_q, regs_data_d;
    logic              miss_q, miss_d;

    logic              cpu_win;
    logic              vid_win;
    logic              starved;

    // ------------------------------------------------------------------
    // Grant decision and vram port drive (same cycle)
    // ------------------------------------------------------------------
    always_comb begin
        starved = PREEMPT_EN && (starve_q >= CNT_MAX);
        cpu_win = (state_q == ST_IDLE) && regs_req_in && (!vid_sel_in || starved);
        vid_win = vid_sel_in && !cpu_win;
    end

    // sel/wr are gated by reset directly so nothing reaches the vram while
    // reset is held, regardless of the request inputs.
    always_comb begin
        vram_sel_out  = (cpu_win || vid_win) && !reset;
        vram_wr_out   = cpu_win && regs_wr_in && !reset;
        vram_addr_out = cpu_win ? regs_addr_in : vid_addr_in;
        vram_data_out = regs_data_in;
    end

    // ------------------------------------------------------------------
    // Next-state: CPU FSM, starvation counter, owner pipe, result registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tag1_d      = TAG_NONE;
        tag2_d      = tag1_q;
        vid_data_d  = vid_data_q;
        regs_data_d = regs_data_q;
        miss_d      = vid_sel_in && cpu_win;

        unique case (state_q)
            ST_IDLE:   if (cpu_win) state_d = ST_ISSUED;
            ST_ISSUED: state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Counts only while a request is actually waiting in IDLE; a busy FSM
        // holds the count, a dropped request or a grant clears it.
        if (cpu_win || !regs_req_in) begin
            starve_d = '0;
        end else if ((state_q == ST_IDLE) && (starve_q < CNT_MAX)) begin
            starve_d = starve_q + 1'b1;
        end

        if (cpu_win) begin
            tag1_d = regs_wr_in ? TAG_NONE : TAG_CPU;
        end else if (vid_win) begin
            tag1_d = TAG_VID;
        end

        // Data arriving now belongs to last cycle's issue.
        unique case (tag1_q)
            TAG_VID: vid_data_d  = vram_data_in;
            TAG_CPU: regs_data_d = vram_data_in;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            vid_data_q  <= '0;
            regs_data_q <= '0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            vid_data_q  <= vid_data_d;
            regs_data_q <= regs_data_d;
            miss_q      <= miss_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers
    // ------------------------------------------------------------------
    always_comb begin
        vid_valid_out = (tag2_q == TAG_VID);
        vid_data_out  = vid_data_q;
        vid_miss_out  = miss_q;
        regs_ack_out  = (state_q == ST_ACK);
        regs_data_out = regs_data_q;
    end

endmodule
